// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone classic single-transfer initiator.
package wb_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    localparam logic ERR_NONE    = 1'b0;
    localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/wb_init_timer.sv
// Saturating ack-timeout counter; 'expired' flags the last bus cycle before abort.
module wb_init_timer
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // TIMEOUT of 0 disables the abort entirely.
    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one command in, one single-beat bus cycle, one response out.
module wb_initiator
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    state_t state, state_nxt;
    logic   accept;
    logic   expired;

    assign accept = (state == IDLE) && cmd_valid;

    wb_init_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (wb_clk_i),
        .reset   (wb_rst_i),
        .clear   (accept),
        .enable  ((state == BUS) && !wbm_ack_i),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = BUS;
            BUS:     if (wbm_ack_i || expired) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and bus-control outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        cmd_ready = (state == IDLE);
        wbm_cyc_o = (state == BUS);
        wbm_stb_o = (state == BUS);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat   <= '0;
            rsp_err   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (wbm_ack_i) begin
                        rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err <= ERR_NONE;
                    end else if (expired) begin
                        rsp_dat <= '0;
                        rsp_err <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: a counter-slave model on the main instance plus two
// extra instances for the same-edge ack/timeout race and the never-time-out setting.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cv3, cv0;
    logic        cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_ready;

    logic        cmd_ready, rsp_valid, rsp_err, cyc, stb, we_o, ack;
    logic [31:0] rsp_dat, adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;

    logic        cmd_ready3, rsp_valid3, rsp_err3, cyc3, stb3, we3, ack3;
    logic [31:0] rsp_dat3, adr3, dato3, dat3;
    logic [3:0]  sel3;

    logic        cmd_ready0, rsp_valid0, rsp_err0, cyc0, stb0, we0, ack0;
    logic [31:0] rsp_dat0, adr0, dato0, dat0;
    logic [3:0]  sel0;

    logic        resp_en, force_ack;
    logic [31:0] slave_reg;
    int unsigned cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT(4), .TO_W(8)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_sel_o(sel_o),
        .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
    );

    wb_initiator #(.TIMEOUT(3), .TO_W(8)) u_dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cv3), .cmd_ready(cmd_ready3), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat3), .rsp_err(rsp_err3),
        .wbm_cyc_o(cyc3), .wbm_stb_o(stb3), .wbm_we_o(we3), .wbm_sel_o(sel3),
        .wbm_adr_o(adr3), .wbm_dat_o(dato3), .wbm_ack_i(ack3), .wbm_dat_i(dat3)
    );

    wb_initiator #(.TIMEOUT(0), .TO_W(8)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cv0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat0), .rsp_err(rsp_err0),
        .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_we_o(we0), .wbm_sel_o(sel0),
        .wbm_adr_o(adr0), .wbm_dat_o(dato0), .wbm_ack_i(ack0), .wbm_dat_i(dat0)
    );

    // Counter-slave model: acks in the second cycle of CYC, writes enabled byte lanes.
    assign ack   = force_ack | (resp_en & cyc & (cyc_cnt == 1));
    assign dat_i = slave_reg;

    always @(posedge clk) begin
        if (rst) begin
            slave_reg <= 32'h0000_0010;
            cyc_cnt   <= 0;
        end else begin
            cyc_cnt <= cyc ? cyc_cnt + 1 : 0;
            if (ack && cyc && we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_o[b]) slave_reg[8*b +: 8] <= dat_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_seen"}, {31'b0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst = 1'b1;
        cmd_valid = 1'b0; cv3 = 1'b0; cv0 = 1'b0;
        cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b1; resp_en = 1'b1; force_ack = 1'b0;
        ack3 = 1'b0; ack0 = 1'b0;
        dat3 = 32'hCAFE_F00D; dat0 = 32'h1111_2222;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_cyc",       {31'b0, cyc},       32'd0);
        chk("rst_stb",       {31'b0, stb},       32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_dat",   rsp_dat,            32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("rst_adr",       adr_o,              32'd0);
        chk("rst_sel",       {28'b0, sel_o},     32'd0);
        chk("rst_cmd_ready0", {31'b0, cmd_ready0}, 32'd1);
        @(negedge clk);

        // Read with 1-cycle-ack slave: cyc cycles 1-2, response cycle 3.
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        chk("t1_c1_cyc",       {31'b0, cyc},       32'd1);
        chk("t1_c1_stb",       {31'b0, stb},       32'd1);
        chk("t1_c1_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("t1_c1_adr",       adr_o,              32'h3000_0000);
        chk("t1_c1_sel",       {28'b0, sel_o},     32'hF);
        chk("t1_c1_we",        {31'b0, we_o},      32'd0);
        chk("t1_c1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_c2_cyc",       {31'b0, cyc},       32'd1);
        chk("t1_c2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_c3_cyc",       {31'b0, cyc},       32'd0);
        chk("t1_c3_stb",       {31'b0, stb},       32'd0);
        chk("t1_c3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t1_c3_rsp_dat",   rsp_dat,            32'h0000_0010);
        chk("t1_c3_rsp_err",   {31'b0, rsp_err},   32'd0);
        @(negedge clk);
        chk("t1_c4_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t1_c4_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Partial-lane write, then read back.
        issue(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'b0011);
        chk("t2_dat_o", dat_o,          32'hA5A5_1234);
        chk("t2_sel_o", {28'b0, sel_o}, 32'h3);
        chk("t2_we_o",  {31'b0, we_o},  32'd1);
        chk("t2_cyc",   {31'b0, cyc},   32'd1);
        wait_rsp("t2_wr");
        chk("t2_wr_rsp_dat", rsp_dat,          32'd0);
        chk("t2_wr_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        wait_rsp("t2_rd");
        chk("t2_rd_rsp_dat", rsp_dat, 32'h0000_1234);
        @(negedge clk);

        // Back-pressured response: held stable, second command blocked.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        wait_rsp("t4");
        for (int i = 0; i < 10; i++) begin
            chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("t4_rsp_dat",   rsp_dat,            32'h0000_1234);
            chk("t4_rsp_err",   {31'b0, rsp_err},   32'd0);
            chk("t4_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("t4_cyc",       {31'b0, cyc},       32'd0);
            if (i == 0) begin
                cmd_we = 1'b1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hDEAD_BEEF;
                cmd_sel = 4'hF; cmd_valid = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t4_rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("t4_rel_cyc",       {31'b0, cyc},       32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t4_acc_cyc",   {31'b0, cyc},  32'd1);
        chk("t4_acc_we",    {31'b0, we_o}, 32'd1);
        chk("t4_acc_dat_o", dat_o,         32'hDEAD_BEEF);
        chk("t4_acc_adr",   adr_o,         32'h3000_0004);
        wait_rsp("t4_second");
        chk("t4_second_rsp_dat", rsp_dat, 32'd0);
        @(negedge clk);

        // Reset during BUS cycle 2; a late ack must not produce a response.
        resp_en = 1'b0;
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        @(negedge clk);
        chk("t5_c2_cyc", {31'b0, cyc}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_cyc",       {31'b0, cyc},       32'd0);
        chk("t5_stb",       {31'b0, stb},       32'd0);
        chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t5_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_late_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t5_late_cyc",       {31'b0, cyc},       32'd0);
        chk("t5_late_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        force_ack = 1'b0;
        resp_en = 1'b1;

        // Nonzero read data so the following error response visibly clears it.
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        wait_rsp("rd2");
        chk("rd2_rsp_dat", rsp_dat, 32'h0000_0010);
        @(negedge clk);

        // No responder, TIMEOUT=4: cyc exactly 4 cycles, then error response.
        resp_en = 1'b0;
        issue(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            chk("t3_cyc_high", {31'b0, cyc}, 32'd1);
            @(negedge clk);
        end
        chk("t3_cyc_low",   {31'b0, cyc},       32'd0);
        chk("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t3_rsp_err",   {31'b0, rsp_err},   32'd1);
        chk("t3_rsp_dat",   rsp_dat,            32'd0);
        @(negedge clk);
        chk("t3_done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        resp_en = 1'b1;

        // TIMEOUT=3 with ack in the 3rd BUS cycle: ack wins.
        cmd_we = 1'b0; cmd_adr = 32'h5000_0000; cmd_sel = 4'hF;
        cv3 = 1'b1;
        @(negedge clk);
        cv3 = 1'b0;
        chk("t6_c1_cyc", {31'b0, cyc3}, 32'd1);
        @(negedge clk);
        chk("t6_c2_cyc", {31'b0, cyc3}, 32'd1);
        @(negedge clk);
        chk("t6_c3_cyc", {31'b0, cyc3}, 32'd1);
        ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;
        chk("t6_cyc",       {31'b0, cyc3},       32'd0);
        chk("t6_rsp_valid", {31'b0, rsp_valid3}, 32'd1);
        chk("t6_rsp_err",   {31'b0, rsp_err3},   32'd0);
        chk("t6_rsp_dat",   rsp_dat3,            32'hCAFE_F00D);
        @(negedge clk);

        // TIMEOUT=0 and no ack: cyc never drops.
        cv0 = 1'b1;
        @(negedge clk);
        cv0 = 1'b0;
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cyc0 === 1'b1 && stb0 === 1'b1) hi++;
            @(negedge clk);
        end
        chk("t0_cyc_cycles", hi,                   32'd1000);
        chk("t0_rsp_valid",  {31'b0, rsp_valid0}, 32'd0);
        chk("t0_cyc_still",  {31'b0, cyc0},       32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
